// File: rtl/div_seq_unit.sv
// Multi-cycle signed restoring divider: remainder on hi, quotient on lo.
// Optional macro DIV_EARLY_EXIT_EN skips the iterations when |a| < |b|.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; hi/lo hold the last successful result
// S_CHECK | divisor-zero test, operand magnitudes and signs latched
// S_RUN   | one restoring iteration per cycle, WIDTH cycles
// S_FIX   | sign correction, hi/lo updated, done pulsed next cycle
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d, div0_q, div0_d;

  logic [WIDTH-1:0] mag_a, mag_b, rem_sh, quo_sh;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  assign mag_a  = mag(a_q);
  assign mag_b  = mag(b_q);
  // The dividend sits in quo and shifts out of its MSB as quotient bits enter.
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (b_q == '0) begin
          div0_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          dvs_d     = mag_b;
          quo_d     = mag_a;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem_d = a_q[WIDTH-1];
          state_d   = S_RUN;
`ifdef DIV_EARLY_EXIT_EN
          if (mag_a < mag_b) begin
            quo_d   = '0;
            rem_d   = mag_a;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_RUN: begin
        if (rem_sh >= dvs_q) begin
          rem_d = rem_sh - dvs_q;
          quo_d = quo_sh | WIDTH'(1);
        end else begin
          rem_d = rem_sh;
          quo_d = quo_sh;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = neg_quo_q ? (-quo_q) : quo_q;
        hi_d    = neg_rem_q ? (-rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit; honours DIV_EARLY_EXIT_EN when defined.
module tb_div_seq_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        start = 1'b0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  div_seq_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .start(start),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_div0;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        done_prev = 1'b0, div0_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the oldest expectation whenever the DUT reports completion.
  always @(negedge clock) begin
    if (!reset) begin
      if (done_prev) chk("done_one_cycle", {63'd0, done}, 64'd0);
      if (div0_prev) chk("div0_one_cycle", {63'd0, div0}, 64'd0);
      if (done || div0) begin
        chk("done_div0_exclusive", {63'd0, done & div0}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b div0=%0b with nothing pending", done, div0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("kind_div0", {63'd0, div0}, {63'd0, e.is_div0});
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("latency", 64'(cyc), 64'(e.due));
          chk("busy_at_end", {63'd0, busy}, 64'd0);
        end
      end
    end
    done_prev <= done;
    div0_prev <= div0;
  end

  // Drives one start pulse; returns just after the accepting edge E0.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint sa, sd, q, r;
    int     lat;
    a = av; b = bv; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    sa = longint'($signed(av));
    sd = longint'($signed(bv));
    if (bv == 32'd0) begin
      e.is_div0 = 1'b1;
      lat = 1;
    end else begin
      q = sa / sd;
      r = sa % sd;
      lo_m = q[31:0];
      hi_m = r[31:0];
      e.is_div0 = 1'b0;
      lat = 34;
`ifdef DIV_EARLY_EXIT_EN
      if ((sa < 0 ? -sa : sa) < (sd < 0 ? -sd : sd)) lat = 2;
`endif
    end
    e.hi  = hi_m;
    e.lo  = lo_m;
    e.due = cyc + lat;
    sb.push_back(e);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Returns at the negedge where done/div0 is high (so a new start can overlap it).
  task automatic wait_result();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done || div0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: no done/div0 within 200 cycles");
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_div0", {63'd0, div0}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd7, 32'd2);                 wait_result();
    issue(32'hFFFF_FFF9, 32'd2);         wait_result();
    issue(32'd7, 32'hFFFF_FFFE);         wait_result();
    issue(32'd7, 32'd2);                 wait_result();
    issue(32'd5, 32'd0);                 wait_result();
    @(negedge clock);
    chk("div0_hold_hi", {32'd0, hi}, 64'd1);
    chk("div0_hold_lo", {32'd0, lo}, 64'd3);
    issue(32'h8000_0000, 32'hFFFF_FFFF); wait_result();
    issue(32'd3, 32'd10);                wait_result();
    issue(32'd0, 32'd9);                 wait_result();
    @(negedge clock);

    // Mid-operation reset with ignored start pulses beforehand.
    issue(32'd100, 32'd7);
    repeat (3) @(negedge clock);
    repeat (7) begin
      a = $urandom; b = $urandom; start = 1'b1;
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b1;
    chk("busy_before_reset", {63'd0, busy}, 64'd1);
    @(posedge clock);
    #1;
    sb.delete();
    hi_m = '0; lo_m = '0;
    chk("midop_reset_hi", {32'd0, hi}, 64'd0);
    chk("midop_reset_lo", {32'd0, lo}, 64'd0);
    chk("midop_reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("post_reset_busy", {63'd0, busy}, 64'd0);
    chk("post_reset_hi", {32'd0, hi}, 64'd0);

    // Randomized operations, some issued back-to-back in the done cycle.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] av, bv;
      int sel;
      sel = $urandom_range(0, 7);
      av = (sel < 3) ? 32'($signed(16'($urandom))) : 32'($urandom);
      case (sel % 4)
        0:       bv = 32'd0;
        1:       bv = 32'($urandom_range(1, 20));
        2:       bv = -32'($urandom_range(1, 20));
        default: bv = 32'($urandom);
      endcase
      if (sel == 7) bv = 32'($urandom) | 32'h4000_0000;
      issue(av, bv);
      wait_result();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results never arrived", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
